// File: rtl/univ_shift_reg.sv
// -----------------------------------------------------------------------------
// univ_shift_reg
//
// Parametrised universal shift register with a self-timed burst serializer.
// In IDLE it executes one opcode per accepted request (hold, shift left/right
// with serial fill, rotate left/right, parallel load, arithmetic shift right,
// clear). A start request loads d and streams it out on sout, MSB-first or
// LSB-first, for exactly WIDTH cycles, then pulses done for one cycle.
//
// Parameters:
//   WIDTH    register width, 2..64
//   RST_VAL  value loaded by reset and by the CLEAR opcode
//
// Ports:
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   op        opcode (see op_e), taken when op_valid && op_ready
//   op_valid  opcode request
//   op_ready  high when no burst is in progress
//   sin_l     fill bit entering at the MSB on SHR
//   sin_r     fill bit entering at the LSB on SHL
//   d         parallel data for LOAD and burst start
//   start     burst request (wins over op_valid)
//   dir       burst order sampled at start: 0 MSB-first, 1 LSB-first
//   q         registered contents
//   sout      serial output (q[0] in an LSB-first burst, else q[WIDTH-1])
//   busy      burst in progress
//   done      one-cycle pulse when a burst completes
//   parity    XOR reduction of q (only when USR_PARITY_EN is defined)
//
// Optional feature: define USR_PARITY_EN to add the parity output.
// -----------------------------------------------------------------------------
module univ_shift_reg #(
  parameter int unsigned           WIDTH   = 8,
  parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       op,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic [WIDTH-1:0] d,
  input  logic             start,
  input  logic             dir,
`ifdef USR_PARITY_EN
  output logic             parity,
`endif
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam int unsigned           CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    OP_HOLD  = 3'b000,
    OP_SHL   = 3'b001,
    OP_SHR   = 3'b010,
    OP_ROL   = 3'b011,
    OP_ROR   = 3'b100,
    OP_LOAD  = 3'b101,
    OP_ASR   = 3'b110,
    OP_CLEAR = 3'b111
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      q_q     <= RST_VAL;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Burst takes priority; a simultaneous op request is dropped.
          q_d     = d;
          dir_d   = dir;
          cnt_d   = '0;
          state_d = ST_BURST;
        end else if (op_valid) begin
          unique case (op_e'(op))
            OP_HOLD:  q_d = q_q;
            OP_SHL:   q_d = {q_q[WIDTH-2:0], sin_r};
            OP_SHR:   q_d = {sin_l, q_q[WIDTH-1:1]};
            OP_ROL:   q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            OP_ROR:   q_d = {q_q[0], q_q[WIDTH-1:1]};
            OP_LOAD:  q_d = d;
            OP_ASR:   q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
            OP_CLEAR: q_d = RST_VAL;
            default:  q_d = q_q;
          endcase
        end
      end

      ST_BURST: begin
        // Shift toward whichever end feeds sout, zero-filling behind.
        q_d   = dir_q ? {1'b0, q_q[WIDTH-1:1]} : {q_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          // All WIDTH bits have been presented; the register is empty.
          q_d     = '0;
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy     = (state_q == ST_BURST);
    op_ready = ~busy;
    q        = q_q;
    done     = done_q;
    // LSB-first bursts drain from bit 0; everything else is MSB-out.
    sout     = (busy && dir_q) ? q_q[0] : q_q[WIDTH-1];
  end

`ifdef USR_PARITY_EN
  assign parity = ^q_q;
`endif

endmodule
